haar_stage_scheduler: RTL and testbench

//  Sequences per-stage Haar classifier databases (fifo_stage_database instances) for one candidate window.

---
 rtl/haar_pkg.sv | 17 +
 rtl/haar_stage_watchdog.sv | 25 ++
 rtl/haar_stage_scheduler.sv | 130 +++++++++++++
 tb/tb_haar_stage_scheduler.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/haar_pkg.sv
// haar_pkg: shared types and sizing helpers for the Haar stage scheduler.
//   state_t          scheduler FSM state encoding
//   HAAR_NUM_STAGES  default cascade depth
//   haar_width()     bit width needed to index n values (minimum 1)
package haar_pkg;
   typedef enum logic [2:0] {
      ST_IDLE         = 3'd0,
      ST_ISSUE        = 3'd1,
      ST_WAIT_DB      = 3'd2,
      ST_WAIT_VERDICT = 3'd3,
      ST_DONE         = 3'd4
   } state_t;
   localparam int HAAR_NUM_STAGES = 24;
   function automatic int haar_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/haar_stage_watchdog.sv
// haar_stage_watchdog: per-stage cycle counter with clear/enable and an expiry flag.
//   clk_fpga    clock
//   reset_fpga  synchronous active-high reset
//   i_clear     zero the counter
//   i_enable    count this cycle
//   o_expired   counter has reached TIMEOUT_CYCLES-1
module haar_stage_watchdog
   import haar_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int TIMEOUT_W      = haar_width(TIMEOUT_CYCLES + 1)
) (
   input  logic clk_fpga,
   input  logic reset_fpga,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);
   logic [TIMEOUT_W-1:0] r_count;
   assign o_expired = r_count == TIMEOUT_W'(TIMEOUT_CYCLES - 1);
   // saturates at the expiry value so the flag cannot be lost to wrap-around
   always_ff @(posedge clk_fpga)
      if (reset_fpga || i_clear) r_count <= '0;
      else if (i_enable && !o_expired) r_count <= r_count + TIMEOUT_W'(1);
endmodule

// File: rtl/haar_stage_scheduler.sv
// haar_stage_scheduler: walks the Haar cascade stages for one window, exiting on the first failing stage.
//   clk_fpga / reset_fpga  clock, synchronous active-high reset
//   i_start / o_ready      window request, accepted only while idle
//   o_rden                 one-hot single-cycle read-enable to the current stage database
//   i_end_database         per-stage end-of-database flags (only the current stage's bit matters)
//   i_stage_valid/pass     evaluator verdict for the current stage
//   o_stage_index          stage being evaluated
//   o_done                 one-cycle completion pulse
//   o_face/o_fail_stage    result, held until the next accepted start
//   o_error                watchdog expiry, held like the result
module haar_stage_scheduler
   import haar_pkg::*;
#(
   parameter int NUM_STAGES     = HAAR_NUM_STAGES,
   parameter int STAGE_IDX_W    = haar_width(NUM_STAGES),
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int TIMEOUT_W      = haar_width(TIMEOUT_CYCLES + 1)
) (
   input  logic                   clk_fpga,
   input  logic                   reset_fpga,
   input  logic                   i_start,
   output logic                   o_ready,
   output logic [NUM_STAGES-1:0]  o_rden,
   input  logic [NUM_STAGES-1:0]  i_end_database,
   input  logic                   i_stage_valid,
   input  logic                   i_stage_pass,
   output logic [STAGE_IDX_W-1:0] o_stage_index,
   output logic                   o_done,
   output logic                   o_face,
   output logic [STAGE_IDX_W-1:0] o_fail_stage,
   output logic                   o_error
);
   state_t                 r_state, w_state_nxt;
   logic [STAGE_IDX_W-1:0] r_stage, w_stage_nxt, r_fail_stage, w_fail_nxt;
   logic                   r_face, w_face_nxt, r_error, w_error_nxt;
   logic                   r_ready, r_done;
   logic [NUM_STAGES-1:0]  r_rden;
   logic                   w_end_db, w_verdict, w_last, w_expired, w_waiting;

   assign w_waiting = r_state == ST_WAIT_DB || r_state == ST_WAIT_VERDICT;
   assign w_end_db  = i_end_database[r_stage];
   // a verdict in WAIT_DB only counts together with the current stage's end-of-database
   assign w_verdict = i_stage_valid && (r_state == ST_WAIT_VERDICT || (r_state == ST_WAIT_DB && w_end_db));
   assign w_last    = r_stage == STAGE_IDX_W'(NUM_STAGES - 1);

   haar_stage_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .TIMEOUT_W     (TIMEOUT_W)
   ) u_watchdog (
      .clk_fpga  (clk_fpga),
      .reset_fpga(reset_fpga),
      .i_clear   (r_state == ST_ISSUE),
      .i_enable  (w_waiting),
      .o_expired (w_expired)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_stage_nxt = r_stage;
      w_face_nxt  = r_face;
      w_fail_nxt  = r_fail_stage;
      w_error_nxt = r_error;
      case (r_state)
         ST_IDLE:
            if (i_start) begin
               w_face_nxt  = 1'b0;
               w_fail_nxt  = '0;
               w_error_nxt = 1'b0;
               w_stage_nxt = '0;
               w_state_nxt = ST_ISSUE;
            end
         ST_ISSUE: w_state_nxt = ST_WAIT_DB;
         ST_WAIT_DB, ST_WAIT_VERDICT:
            // verdict takes priority over a watchdog expiry in the same cycle
            if (w_verdict) begin
               if (!i_stage_pass) begin
                  w_face_nxt  = 1'b0;
                  w_fail_nxt  = r_stage;
                  w_state_nxt = ST_DONE;
               end else if (w_last) begin
                  w_face_nxt  = 1'b1;
                  w_fail_nxt  = '0;
                  w_state_nxt = ST_DONE;
               end else begin
                  w_stage_nxt = r_stage + STAGE_IDX_W'(1);
                  w_state_nxt = ST_ISSUE;
               end
            end else if (w_expired) begin
               w_error_nxt = 1'b1;
               w_face_nxt  = 1'b0;
               w_fail_nxt  = r_stage;
               w_state_nxt = ST_DONE;
            end else if (r_state == ST_WAIT_DB && w_end_db) begin
               w_state_nxt = ST_WAIT_VERDICT;
            end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // outputs are decoded from the next state so they line up with the state they describe
   always_ff @(posedge clk_fpga)
      if (reset_fpga) begin
         r_state      <= ST_IDLE;
         r_stage      <= '0;
         r_face       <= 1'b0;
         r_fail_stage <= '0;
         r_error      <= 1'b0;
         r_ready      <= 1'b1;
         r_done       <= 1'b0;
         r_rden       <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_stage      <= w_stage_nxt;
         r_face       <= w_face_nxt;
         r_fail_stage <= w_fail_nxt;
         r_error      <= w_error_nxt;
         r_ready      <= w_state_nxt == ST_IDLE;
         r_done       <= w_state_nxt == ST_DONE;
         r_rden       <= (w_state_nxt == ST_ISSUE) ? NUM_STAGES'(1) << w_stage_nxt : '0;
      end

   assign o_ready       = r_ready;
   assign o_rden        = r_rden;
   assign o_stage_index = r_stage;
   assign o_done        = r_done;
   assign o_face        = r_face;
   assign o_fail_stage  = r_fail_stage;
   assign o_error       = r_error;
endmodule

// File: tb/tb_haar_stage_scheduler.sv
// tb_haar_stage_scheduler: directed self-checking bench for haar_stage_scheduler.
module tb_haar_stage_scheduler;
   logic        clk_fpga = 1'b0;
   logic        reset_fpga, i_start, i_stage_valid, i_stage_pass;
   logic [23:0] i_end_database, o_rden;
   logic [4:0]  o_stage_index, o_fail_stage;
   logic        o_ready, o_done, o_face, o_error;
   int          checks = 0, failures = 0, rden_cnt = 0, onehot_bad = 0, cyc = 0;
   bit          noise = 0;

   haar_stage_scheduler dut (
      .clk_fpga      (clk_fpga),
      .reset_fpga    (reset_fpga),
      .i_start       (i_start),
      .o_ready       (o_ready),
      .o_rden        (o_rden),
      .i_end_database(i_end_database),
      .i_stage_valid (i_stage_valid),
      .i_stage_pass  (i_stage_pass),
      .o_stage_index (o_stage_index),
      .o_done        (o_done),
      .o_face        (o_face),
      .o_fail_stage  (o_fail_stage),
      .o_error       (o_error)
   );

   always #5 clk_fpga = ~clk_fpga;
   always @(posedge clk_fpga) cyc++;
   always @(negedge clk_fpga) begin
      if (o_rden != 0) rden_cnt++;
      if ($countones(o_rden) > 1) onehot_bad++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk_fpga);
   endtask

   task automatic start_window(output int t0);
      i_start = 1'b1;
      t0 = cyc;
      tick();
      i_start = 1'b0;
   endtask

   task automatic wait_rden(input int s, output int t);
      int n = 0;
      while (o_rden == 0 && n < 50) begin
         tick();
         n++;
      end
      check("rden_wait", 32'(n < 50), 1);
      check("rden_onehot", o_rden, 24'(1) << s);
      check("stage_idx", o_stage_index, s);
      t = cyc;
   endtask

   // answer stage s lat cycles after its rden; returns at the cycle after the verdict edge
   task automatic serve(input int s, input int lat, input bit pass, output int t);
      wait_rden(s, t);
      for (int k = 0; k < lat; k++) begin
         tick();
         if (k == 0) check("rden_pulse", o_rden, 0);
         if (noise) begin
            i_start = 1'b1;
            i_end_database = ~(24'(1) << s);
         end
      end
      i_start = 1'b0;
      i_end_database = 24'(1) << s;
      i_stage_valid = 1'b1;
      i_stage_pass = pass;
      tick();
      i_end_database = '0;
      i_stage_valid = 1'b0;
      i_stage_pass = 1'b0;
   endtask

   task automatic check_result(input string tag, input bit face, input int fail, input bit err);
      check({tag, "_done"}, o_done, 1);
      check({tag, "_face"}, o_face, face);
      check({tag, "_fail"}, o_fail_stage, fail);
      check({tag, "_err"}, o_error, err);
   endtask

   initial begin
      int t0, t, tp, base, n;
      reset_fpga = 1'b1;
      i_start = 1'b0;
      i_stage_valid = 1'b0;
      i_stage_pass = 1'b0;
      i_end_database = '0;
      repeat (2) tick();
      reset_fpga = 1'b0;
      check("rst_ready", o_ready, 1);
      check("rst_rden", o_rden, 0);
      check("rst_idx", o_stage_index, 0);
      check("rst_done", o_done, 0);
      check("rst_face", o_face, 0);
      check("rst_fail", o_fail_stage, 0);
      check("rst_err", o_error, 0);

      // stray verdict and end_db while idle
      base = rden_cnt;
      i_stage_valid = 1'b1;
      i_end_database = '1;
      repeat (3) tick();
      i_stage_valid = 1'b0;
      i_end_database = '0;
      tick();
      #1;
      check("idle_ready", o_ready, 1);
      check("idle_done", o_done, 0);
      check("idle_rden", rden_cnt - base, 0);

      // all 24 stages pass, answer 3 cycles after each rden
      base = rden_cnt;
      start_window(t0);
      check("first_rden_lat", cyc - t0, 1);
      tp = 0;
      for (int s = 0; s < 24; s++) begin
         serve(s, 3, 1'b1, t);
         if (s > 0) check("period4", t - tp, 4);
         tp = t;
      end
      check_result("allpass", 1'b1, 0, 1'b0);
      check("allpass_cycles", cyc - t0, 97);
      tick();
      #1;
      check("allpass_pulse", o_done, 0);
      check("allpass_ready", o_ready, 1);
      check("allpass_rdens", rden_cnt - base, 24);

      // early fail at stage 5
      base = rden_cnt;
      start_window(t0);
      for (int s = 0; s < 6; s++) serve(s, 2, s != 5, t);
      check_result("fail5", 1'b0, 5, 1'b0);
      repeat (5) tick();
      #1;
      check("fail5_rdens", rden_cnt - base, 6);
      check("fail5_ready", o_ready, 1);
      check("fail5_hold", o_fail_stage, 5);

      // same-cycle end_db and verdict: 2 cycles per stage
      start_window(t0);
      tp = 0;
      for (int s = 0; s < 24; s++) begin
         serve(s, 1, 1'b1, t);
         if (s > 0) check("period2", t - tp, 2);
         tp = t;
      end
      check_result("fast", 1'b1, 0, 1'b0);
      check("fast_cycles", cyc - t0, 49);
      tick();

      // stage 3 never ends its database: watchdog
      start_window(t0);
      for (int s = 0; s < 3; s++) serve(s, 1, 1'b1, t);
      wait_rden(3, t);
      n = 0;
      while (!o_done && n < 5000) begin
         tick();
         n++;
      end
      check("wd_cycles", n, 4097);
      check_result("wd", 1'b0, 3, 1'b1);
      tick();
      check("wd_ready", o_ready, 1);
      check("wd_err_hold", o_error, 1);

      // restart pulses and foreign end_db bits mid-evaluation, fail at stage 7
      base = rden_cnt;
      noise = 1'b1;
      start_window(t0);
      check("restart_err_clr", o_error, 0);
      for (int s = 0; s < 8; s++) serve(s, 3, s != 7, t);
      noise = 1'b0;
      check_result("noise", 1'b0, 7, 1'b0);
      repeat (5) tick();
      #1;
      check("noise_rdens", rden_cnt - base, 8);
      check("noise_ready", o_ready, 1);

      // reset during WAIT_VERDICT of stage 10
      start_window(t0);
      for (int s = 0; s < 10; s++) serve(s, 1, 1'b1, t);
      wait_rden(10, t);
      tick();
      i_end_database = 24'(1) << 10;
      tick();
      i_end_database = '0;
      check("wv_ready", o_ready, 0);
      reset_fpga = 1'b1;
      tick();
      reset_fpga = 1'b0;
      check("mid_rst_ready", o_ready, 1);
      check("mid_rst_rden", o_rden, 0);
      check("mid_rst_idx", o_stage_index, 0);
      check("mid_rst_done", o_done, 0);
      check("mid_rst_face", o_face, 0);
      check("mid_rst_fail", o_fail_stage, 0);
      check("mid_rst_err", o_error, 0);
      start_window(t0);
      check("post_rst_lat", cyc - t0, 1);
      for (int s = 0; s < 24; s++) serve(s, 1, 1'b1, t);
      check_result("post_rst", 1'b1, 0, 1'b0);
      tick();
      check("onehot_bad", onehot_bad, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
